// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, line levels and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Parity over a zero-extended word; odd=1 inverts to give odd parity.
    function automatic logic uart_parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit clock counter with a last-clock strobe
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count clocks within a bit; wrap at the last clock, hold at 0 while cleared.
    always_comb begin
        bit_done = (cnt_q == LAST);
        cnt_d    = cnt_q + CNT_W'(1);
        if (clear) begin
            cnt_d = '0;
        end else if (bit_done) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - valid/ready fed UART frame transmitter
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shift_next;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              bit_done;
    logic              timer_clear;

    // The timer runs only while a frame is in flight, so it restarts at 0 on accept.
    assign timer_clear = (state_q == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .bit_done (bit_done)
    );

    assign ready      = (state_q == IDLE);
    assign busy       = !ready;
    assign tx         = tx_q;
    assign shift_next = shift_q >> 1;

    // Next-state and next line level; tx_d is the level of the bit that begins next clock.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (valid) begin
                    state_d   = START;
                    shift_d   = d;
                    bit_idx_d = '0;
                    parity_d  = uart_parity(16'(d), PARITY_ODD != 0);
                    tx_d      = UART_START_LVL;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_next;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = UART_IDLE_LVL;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        tx_d      = shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = UART_IDLE_LVL;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = UART_IDLE_LVL;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= UART_IDLE_LVL;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial UART transmitter: accepts one `DATA_W`-bit word over a valid/ready handshake and drives it onto a single line. The frame is one start bit (0), data LSB first, an optional parity bit, then one stop bit (1). Each bit is held for `CLKS_PER_BIT` clocks. It is the transmit end of the team's serial link and pairs with the serial receiver on the far side.

## Interface
Parameters:
- `DATA_W`, 8 — payload bits per frame (1..16)
- `CLKS_PER_BIT`, 16 — clocks per serial bit (≥2)
- `PARITY_EN`, 0 — 1 inserts a parity bit after the data
- `PARITY_ODD`, 0 — 0 = even parity, 1 = odd parity; ignored when `PARITY_EN`=0

Ports:
- `clk` input 1 — single clock; every flop is rising-edge
- `reset` input 1 — synchronous, active-low; sampled only on the `clk` rising edge
- `d` input `DATA_W` — word to send; sampled on the accept edge only
- `valid` input 1 — `d` is offered
- `ready` output 1 — block is idle and will accept
- `tx` output 1 — serial line, idles high
- `busy` output 1 — a frame is in progress

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- In IDLE, `ready`=1, `busy`=0, `tx`=1.
- Accept occurs at an edge where `valid`&&`ready`=1. At that edge:
  - `d` is latched into the shift register.
  - The FSM moves IDLE→START.
  - The bit counter and clock counter clear to 0.
- START: `tx`=0 for `CLKS_PER_BIT` clocks, then →DATA.
- DATA:
  - `tx` = shift_reg[0].
  - After `CLKS_PER_BIT` clocks, shift right and increment the bit index.
  - After bit index `DATA_W`-1, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: `tx` = ^latched_data XOR `PARITY_ODD`, for `CLKS_PER_BIT` clocks, then →STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` clocks, then →IDLE.
- `ready` and `busy` are decoded from the state: `ready` = (state==IDLE) and `busy` = !ready.
- `valid` while not ready is ignored. No internal queue. A changing `d` mid-frame has no effect.
- Counter widths:
  - clock counter: $clog2(`CLKS_PER_BIT`)
  - bit index: $clog2(`DATA_W`+1)
  - Both wrap to 0 at each bit boundary. Counting is unsigned with no saturation.
- Reset:
  - When `reset`=0 at an edge: state=IDLE, counters=0, shift register=0.
  - From the next clock: `tx`=1, `ready`=1, `busy`=0.
  - This holds in any state. A frame in flight is abandoned, with no partial stop bit. `valid` during reset is not accepted.
- `reset` and `valid` both asserted on the same edge: reset wins, and nothing is accepted.

## Timing
- Latency: `tx` falls on the first clock after the accept edge.
- Frame length: N = (2 + `DATA_W` + `PARITY_EN`) × `CLKS_PER_BIT` clocks, measured from the accept edge to the re-entry into IDLE.
- `ready` rises on the clock after the last STOP clock.
- Back-to-back accepts: the minimum accept-to-accept spacing is N+1 clocks, i.e. at least one IDLE clock with `tx`=1 between frames.
- `tx` is driven by a flop. No glitches. Not combinational from `d` or `valid`.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - `UART_IDLE_LVL`=1'b1, `UART_START_LVL`=1'b0
  - The receiver reuses this package.
- One sub-module, `uart_bit_timer`:
  - parameterized by `CLKS_PER_BIT`
  - inputs: `clk`, `reset`, `clear`
  - output: one-cycle `bit_done` pulse on the last clock of each bit
  - Same reset style as the parent.

## Test plan
- Basic frame. Setup: `DATA_W`=8, `CLKS_PER_BIT`=4, no parity. Stimulus: `d`=8'hA5 with `valid` pulse. Response:
  - `tx` = 0 ×4, then 1,0,1,0,0,1,0,1 each ×4, then 1 ×4.
  - `busy` high for exactly 40 clocks.
  - `ready` high on clock 41.
- Parity. Setup: `PARITY_EN`=1. Stimulus: 8'hA5. Response:
  - Even parity: parity bit = 0.
  - `PARITY_ODD`=1: parity bit = 1.
  - 8'h01 with even parity: parity bit = 1.
  - Frame = 44 clocks.
- Back-to-back. Stimulus: `valid` held high with 8'h3C then 8'hC3. Response: second start bit begins exactly 41 clocks after the first accept; both payloads are serialized correctly.
- Ignored valid. Stimulus: `valid` with 8'hFF pulsed at clock 10 of an 8'h00 frame. Response: all data bits stay 0; no second frame follows.
- Reset mid-frame. Stimulus: `reset`=0 during DATA bit 3. Response: next clock `tx`=1, `ready`=1, `busy`=0; a new 8'h5A accepted afterwards is sent intact.
- Reset vs valid collision. Stimulus: `reset`=0 and `valid`=1 on the same edge. Response: no start bit; `tx` stays 1.
